// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields, MEM/WB bypass sources, and EX-facing results.
// The master drives ID and bypass signals; the slave (the stage) returns EX operands and hazard request.
interface id_ex_stage_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          stall;
   logic          flush;
   logic          id_valid;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic [AW-1:0] id_rd;
   logic [DW-1:0] id_rs_data;
   logic [DW-1:0] id_rt_data;
   logic [15:0]   id_imm;
   logic          id_signext;
   logic          id_alusrc;
   logic          id_regdst;
   logic [3:0]    id_func;
   logic          id_regwrite;
   logic          id_memread;
   logic          id_memwrite;
   logic          id_memtoreg;
   logic          mem_regwrite;
   logic [AW-1:0] mem_dst;
   logic [DW-1:0] mem_result;
   logic          wb_regwrite;
   logic [AW-1:0] wb_dst;
   logic [DW-1:0] wb_result;
   logic [DW-1:0] ex_in1;
   logic [DW-1:0] ex_in2;
   logic [3:0]    ex_func;
   logic [DW-1:0] ex_store_data;
   logic [AW-1:0] ex_dst;
   logic          ex_valid;
   logic          ex_regwrite;
   logic          ex_memread;
   logic          ex_memwrite;
   logic          ex_memtoreg;
   logic          load_use_stall;

   modport master (
      output stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
             id_imm, id_signext, id_alusrc, id_regdst, id_func,
             id_regwrite, id_memread, id_memwrite, id_memtoreg,
             mem_regwrite, mem_dst, mem_result, wb_regwrite, wb_dst, wb_result,
      input  ex_in1, ex_in2, ex_func, ex_store_data, ex_dst,
             ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall
   );

   modport slave (
      input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
             id_imm, id_signext, id_alusrc, id_regdst, id_func,
             id_regwrite, id_memread, id_memwrite, id_memtoreg,
             mem_regwrite, mem_dst, mem_result, wb_regwrite, wb_dst, wb_result,
      output ex_in1, ex_in2, ex_func, ex_store_data, ex_dst,
             ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding; one cycle ID capture to EX operands.
// stall freezes the stage (held operands keep absorbing bypasses), flush/load-use insert a bubble.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
);
   logic          r_valid;
   logic          r_regwrite;
   logic          r_memread;
   logic          r_memwrite;
   logic          r_memtoreg;
   logic          r_alusrc;
   logic [3:0]    r_func;
   logic [AW-1:0] r_rs;
   logic [AW-1:0] r_rt;
   logic [AW-1:0] r_dst;
   logic [DW-1:0] r_rsd;
   logic [DW-1:0] r_rtd;
   logic [DW-1:0] r_imm;

   logic [DW-1:0] w_rs_fwd;
   logic [DW-1:0] w_rt_fwd;
   logic [DW-1:0] w_rs_cap;
   logic [DW-1:0] w_rt_cap;
   logic [DW-1:0] w_imm_ext;
   logic          w_load_use;

   // MEM outranks WB; $0 is hardwired and never takes a bypass.
   always_comb begin
      w_rs_fwd = r_rsd;
      if (r_rs != '0 && bus.mem_regwrite && bus.mem_dst == r_rs)
         w_rs_fwd = bus.mem_result;
      else if (r_rs != '0 && bus.wb_regwrite && bus.wb_dst == r_rs)
         w_rs_fwd = bus.wb_result;

      w_rt_fwd = r_rtd;
      if (r_rt != '0 && bus.mem_regwrite && bus.mem_dst == r_rt)
         w_rt_fwd = bus.mem_result;
      else if (r_rt != '0 && bus.wb_regwrite && bus.wb_dst == r_rt)
         w_rt_fwd = bus.wb_result;
   end

   // WB bypass at capture stands in for a write-first register file.
   assign w_rs_cap = (bus.id_rs != '0 && bus.wb_regwrite && bus.wb_dst == bus.id_rs)
                     ? bus.wb_result : bus.id_rs_data;
   assign w_rt_cap = (bus.id_rt != '0 && bus.wb_regwrite && bus.wb_dst == bus.id_rt)
                     ? bus.wb_result : bus.id_rt_data;
   assign w_imm_ext = bus.id_signext ? {{(DW-16){bus.id_imm[15]}}, bus.id_imm}
                                     : {{(DW-16){1'b0}}, bus.id_imm};

   assign w_load_use = bus.id_valid && r_valid && r_memread && r_dst != '0 &&
                       (r_dst == bus.id_rs || r_dst == bus.id_rt);

   assign bus.load_use_stall = w_load_use;
   assign bus.ex_in1         = r_valid ? w_rs_fwd : '0;
   assign bus.ex_store_data  = r_valid ? w_rt_fwd : '0;
   assign bus.ex_in2         = !r_valid ? '0 : (r_alusrc ? r_imm : w_rt_fwd);
   assign bus.ex_func        = r_func;
   assign bus.ex_dst         = r_dst;
   assign bus.ex_valid       = r_valid;
   assign bus.ex_regwrite    = r_regwrite;
   assign bus.ex_memread     = r_memread;
   assign bus.ex_memwrite    = r_memwrite;
   assign bus.ex_memtoreg    = r_memtoreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || bus.flush) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_alusrc   <= 1'b0;
         r_func     <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_dst      <= '0;
         r_rsd      <= '0;
         r_rtd      <= '0;
         r_imm      <= '0;
      end else if (bus.stall) begin
         // Frozen instruction keeps collecting results retiring from MEM/WB.
         r_rsd <= w_rs_fwd;
         r_rtd <= w_rt_fwd;
      end else if (w_load_use) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_alusrc   <= 1'b0;
         r_func     <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_dst      <= '0;
         r_rsd      <= '0;
         r_rtd      <= '0;
         r_imm      <= '0;
      end else begin
         r_valid    <= bus.id_valid;
         r_regwrite <= bus.id_regwrite & bus.id_valid;
         r_memread  <= bus.id_memread  & bus.id_valid;
         r_memwrite <= bus.id_memwrite & bus.id_valid;
         r_memtoreg <= bus.id_memtoreg & bus.id_valid;
         r_alusrc   <= bus.id_alusrc;
         r_func     <= bus.id_func;
         r_rs       <= bus.id_rs;
         r_rt       <= bus.id_rt;
         r_dst      <= bus.id_regdst ? bus.id_rd : bus.id_rt;
         r_rsd      <= w_rs_cap;
         r_rtd      <= w_rt_cap;
         r_imm      <= w_imm_ext;
      end
   end
endmodule
